// File: rtl/vram_scanout.sv
// VGA 640x480@60 scan-out of the VRAM frame store: timing generation, 2x2 upscaled
// pixel fetch into a centred window, and ADV7123 DAC pin drive at CLOCK_50/2.
module vram_scanout #(
    parameter int unsigned       DATA_W = 24,
    parameter int unsigned       ADR_W  = 16,
    parameter int unsigned       SRC_W  = 280,
    parameter int unsigned       SRC_H  = 192,
    parameter int unsigned       X_OFF  = 40,
    parameter int unsigned       Y_OFF  = 48,
    parameter logic [DATA_W-1:0] BORDER = 24'h000000,
    parameter int unsigned       H_ACT  = 640,
    parameter int unsigned       H_FP   = 16,
    parameter int unsigned       H_SYNC = 96,
    parameter int unsigned       H_BP   = 48,
    parameter int unsigned       V_ACT  = 480,
    parameter int unsigned       V_FP   = 10,
    parameter int unsigned       V_SYNC = 2,
    parameter int unsigned       V_BP   = 33
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    output logic [ADR_W-1:0]  vram_radr,
    input  logic [DATA_W-1:0] vram_q,
    output logic              frame_start,
    output logic [7:0]        VGA_R,
    output logic [7:0]        VGA_G,
    output logic [7:0]        VGA_B,
    output logic              VGA_CLK,
    output logic              VGA_BLANK_N,
    output logic              VGA_SYNC_N,
    output logic              VGA_HS,
    output logic              VGA_VS
);

    localparam int unsigned H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW    = $clog2(H_TOT);
    localparam int unsigned VW    = $clog2(V_TOT);

    localparam logic [HW-1:0]    H_LAST   = HW'(H_TOT - 1);
    localparam logic [HW-1:0]    H_ACT_E  = HW'(H_ACT);
    localparam logic [HW-1:0]    HS_BEG   = HW'(H_ACT + H_FP);
    localparam logic [HW-1:0]    HS_END   = HW'(H_ACT + H_FP + H_SYNC);
    localparam logic [HW-1:0]    X_BEG    = HW'(X_OFF);
    localparam logic [HW-1:0]    X_END    = HW'(X_OFF + 2 * SRC_W);
    localparam logic [VW-1:0]    V_LAST   = VW'(V_TOT - 1);
    localparam logic [VW-1:0]    V_ACT_E  = VW'(V_ACT);
    localparam logic [VW-1:0]    VS_BEG   = VW'(V_ACT + V_FP);
    localparam logic [VW-1:0]    VS_END   = VW'(V_ACT + V_FP + V_SYNC);
    localparam logic [VW-1:0]    Y_BEG    = VW'(Y_OFF);
    localparam logic [VW-1:0]    Y_END    = VW'(Y_OFF + 2 * SRC_H);
    localparam logic [ADR_W-1:0] ROW_STEP = ADR_W'(SRC_W);

    logic             pix_en;
    logic [HW-1:0]    h_cnt;
    logic [VW-1:0]    v_cnt;
    logic [ADR_W-1:0] row_base;

    logic             in_rows;
    logic             in_win;
    logic             active;
    logic             hs_n;
    logic             vs_n;
    logic             row_odd;
    logic [HW-1:0]    h_rel;

    // First delay stage: raster attributes of the pixel whose address was just issued.
    logic             hs_d;
    logic             vs_d;
    logic             act_d;
    logic             win_d;

    always_comb begin
        in_rows = (v_cnt >= Y_BEG) && (v_cnt < Y_END);
        in_win  = in_rows && (h_cnt >= X_BEG) && (h_cnt < X_END);
        active  = (h_cnt < H_ACT_E) && (v_cnt < V_ACT_E);
        hs_n    = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
        vs_n    = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
        row_odd = v_cnt[0] ^ Y_BEG[0];
        h_rel   = h_cnt - X_BEG;
    end

    assign VGA_SYNC_N = 1'b0;

    // Half-rate pixel enable; VGA_CLK rises one cycle after each pin update.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            pix_en      <= 1'b0;
            VGA_CLK     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pix_en      <= ~pix_en;
            VGA_CLK     <= ~pix_en;
            frame_start <= !pix_en && (h_cnt == '0) && (v_cnt == '0);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // Row base steps by one source line after every second window line, so each
    // source row is fetched twice without a multiplier.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            row_base  <= '0;
            vram_radr <= '0;
        end else if (pix_en) begin
            if (v_cnt == '0) begin
                row_base <= '0;
            end else if ((h_cnt == H_LAST) && in_rows && row_odd) begin
                row_base <= row_base + ROW_STEP;
            end
            if (in_win) begin
                vram_radr <= row_base + ADR_W'(h_rel >> 1);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            hs_d  <= 1'b1;
            vs_d  <= 1'b1;
            act_d <= 1'b0;
            win_d <= 1'b0;
        end else if (pix_en) begin
            hs_d  <= hs_n;
            vs_d  <= vs_n;
            act_d <= active;
            win_d <= in_win;
        end
    end

    // The RAM answer for the address issued one pixel ago is on vram_q during the
    // pix_en cycle, so it joins the delayed attributes directly at the pins.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
        end else if (pix_en) begin
            VGA_HS      <= hs_d;
            VGA_VS      <= vs_d;
            VGA_BLANK_N <= act_d;
            if (act_d && win_d) begin
                VGA_R <= vram_q[23:16];
                VGA_G <= vram_q[15:8];
                VGA_B <= vram_q[7:0];
            end else if (act_d) begin
                VGA_R <= BORDER[23:16];
                VGA_G <= BORDER[15:8];
                VGA_B <= BORDER[7:0];
            end else begin
                VGA_R <= '0;
                VGA_G <= '0;
                VGA_B <= '0;
            end
        end
    end

endmodule
